// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer controller slice.
// Holds the default geometry and a constant ceil-log2 helper that the
// controller uses to size its address and occupancy fields.
package buffer_pkg;

  localparam int DEF_SIZE = 32'sd16;
  localparam int DEF_K    = 32'sd4;
  localparam int DEF_J    = 32'sd4;

  // Smallest r with 2**r >= value; used for BIT (SIZE) and CNT_BIT (SIZE+1).
  function automatic int clog2_f(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_ptr.sv
// Modular pointer: a BIT-wide register that advances by STEP when adv is
// high and wraps by natural overflow (depth is a power of two).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset to 0
//   clr  - synchronous clear to 0 (flush)
//   adv  - advance the pointer by STEP this edge
//   ptr  - current pointer value
module mod_ptr #(
  parameter int BIT  = 32'sd4,
  parameter int STEP = 32'sd4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           adv,
  output logic [BIT-1:0] ptr
);

  // STEP == depth truncates to 0, which is the correct modular advance.
  localparam logic [BIT-1:0] STEP_W = BIT'(STEP);

  // Pointer register: reset/clear win over advance.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= {BIT{1'b0}};
    end else if (adv) begin
      ptr <= ptr + STEP_W;
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/buffer_ctrl.sv
// Pointer and occupancy controller in front of the circular line Buffer.
// Accepts K-word write groups and presents J-word read groups, driving the
// Buffer's ld / write_add / read_add so it never overflows or underflows.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   flush               - synchronous clear of pointers and count
//   wr_valid / wr_ready - producer handshake (K words)
//   rd_ready / rd_valid - consumer handshake (J words)
//   ld                  - Buffer load enable (same-cycle write fire)
//   write_add/read_add  - Buffer write/read base addresses
//   count, full, empty  - occupancy in words and its flags
module buffer_ctrl
  import buffer_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int K       = DEF_K,
  parameter int J       = DEF_J,
  parameter int BIT     = clog2_f(SIZE),
  parameter int CNT_BIT = clog2_f(SIZE + 32'sd1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic               ld,
  output logic [BIT-1:0]     write_add,
  output logic [BIT-1:0]     read_add,
  output logic [CNT_BIT-1:0] count,
  output logic               full,
  output logic               empty
);

  localparam logic [CNT_BIT-1:0] SIZE_C = CNT_BIT'(SIZE);
  localparam logic [CNT_BIT-1:0] K_C    = CNT_BIT'(K);
  localparam logic [CNT_BIT-1:0] J_C    = CNT_BIT'(J);

  logic [CNT_BIT-1:0] cnt;
  logic [CNT_BIT-1:0] cnt_next;
  logic [CNT_BIT-1:0] room;
  logic               wr_fire;
  logic               rd_fire;

  // Handshake qualification: both sides blocked during reset or flush.
  always_comb begin
    room     = SIZE_C - cnt;
    wr_ready = !rst && !flush && (room >= K_C);
    rd_valid = !rst && !flush && (cnt >= J_C);
    wr_fire  = wr_valid && wr_ready;
    rd_fire  = rd_ready && rd_valid;
    ld       = wr_fire;
  end

  // Next occupancy; both fires are judged on the pre-edge count, so
  // cnt + K never exceeds SIZE and cnt - J never goes below zero.
  always_comb begin
    cnt_next = cnt;
    if (wr_fire && rd_fire) begin
      cnt_next = cnt + K_C - J_C;
    end else if (wr_fire) begin
      cnt_next = cnt + K_C;
    end else if (rd_fire) begin
      cnt_next = cnt - J_C;
    end else begin
      cnt_next = cnt;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= {CNT_BIT{1'b0}};
    end else begin
      cnt <= cnt_next;
    end
  end

  mod_ptr #(.BIT(BIT), .STEP(K)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .adv (wr_fire),
    .ptr (write_add)
  );

  mod_ptr #(.BIT(BIT), .STEP(J)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .adv (rd_fire),
    .ptr (read_add)
  );

  // Occupancy outputs straight from the count register.
  always_comb begin
    count = cnt;
    full  = (cnt == SIZE_C);
    empty = (cnt == {CNT_BIT{1'b0}});
  end

endmodule
